intersection_scheduler: RTL and testbench

INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

---
 rtl/traffic_pkg.sv | 16 +
 rtl/phase_timer.sv | 17 +
 rtl/intersection_scheduler.sv | 92 +++++++++
 tb/tb_intersection_scheduler.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared phase encoding and lamp drive constants for the intersection scheduler
package traffic_pkg;
   typedef enum logic [2:0] {
      OFF  = 3'd0,
      NS_G = 3'd1,
      NS_Y = 3'd2,
      AR1  = 3'd3,
      EW_G = 3'd4,
      EW_Y = 3'd5,
      AR2  = 3'd6
   } phase_e;
   localparam logic [2:0] RED  = 3'b100;
   localparam logic [2:0] YEL  = 3'b010;
   localparam logic [2:0] GRN  = 3'b001;
   localparam logic [2:0] DARK = 3'b000;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: tick-enabled up-counter with clear, holding at dur-1 so done stays asserted while resting
module phase_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tick,
   input  logic         clr,
   input  logic [W-1:0] dur,
   output logic [W-1:0] count,
   output logic         done
);
   assign done = count == dur - W'(1);
   always_ff @(posedge clk)
      if (rst || clr) count <= '0;
      else if (tick && !done) count <= count + W'(1);
endmodule

// File: rtl/intersection_scheduler.sv
// intersection_scheduler: two-way signal controller with side-street demand, pedestrian walk and dark mode
module intersection_scheduler
   import traffic_pkg::*;
#(
   parameter int GREEN_TICKS  = 8,
   parameter int YELLOW_TICKS = 2,
   parameter int ALLRED_TICKS = 1,
   parameter int WALK_TICKS   = 4,
   parameter int TIMER_W      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       off,
   input  logic       ped_ns,
   input  logic       ped_ew,
   input  logic       car_ew,
   output logic [2:0] ns_rgy,
   output logic [2:0] ew_rgy,
   output logic       walk_ns,
   output logic       walk_ew,
   output logic       buzz_en,
   output logic [2:0] phase
);
   localparam logic [TIMER_W-1:0] G_DUR = TIMER_W'(GREEN_TICKS);
   localparam logic [TIMER_W-1:0] Y_DUR = TIMER_W'(YELLOW_TICKS);
   localparam logic [TIMER_W-1:0] A_DUR = TIMER_W'(ALLRED_TICKS);
   localparam logic [TIMER_W-1:0] W_END = TIMER_W'(WALK_TICKS > 0 ? WALK_TICKS - 1 : 0);
   localparam logic W_ON = WALK_TICKS > 0;
   phase_e state, next;
   logic [TIMER_W-1:0] count, dur;
   logic done, expire, pend_ns, pend_ew, enter_ns, enter_ew;
   logic [2:0] ns_n, ew_n;
   logic walk_ns_n, walk_ew_n;
   assign dur = (state == NS_G || state == EW_G) ? G_DUR :
                (state == NS_Y || state == EW_Y) ? Y_DUR : A_DUR;
   assign expire = tick && done;
   assign enter_ns = next == NS_G && state != NS_G;
   assign enter_ew = next == EW_G && state != EW_G;
   assign phase = state;
   assign buzz_en = walk_ns | walk_ew;
   phase_timer #(.W(TIMER_W)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .clr   (next != state),
      .dur   (dur),
      .count (count),
      .done  (done)
   );
   always_ff @(posedge clk)
      if (rst) state <= AR2;
      else state <= next;
   always_comb begin
      next = state;
      if (off) next = OFF;
      else
         case (state)
            OFF:     next = AR2;
            AR2:     if (expire) next = NS_G;
            NS_G:    if (expire && (car_ew || pend_ew || pend_ns)) next = NS_Y;
            NS_Y:    if (expire) next = AR1;
            AR1:     if (expire) next = EW_G;
            EW_G:    if (expire) next = EW_Y;
            EW_Y:    if (expire) next = AR2;
            default: next = AR2;
         endcase
   end
   // Outputs are decoded from next so the registers line up with the state register
   always_comb begin
      ns_n = next == OFF ? DARK : next == NS_G ? GRN : next == NS_Y ? YEL : RED;
      ew_n = next == OFF ? DARK : next == EW_G ? GRN : next == EW_Y ? YEL : RED;
      walk_ns_n = next == NS_G && (enter_ns ? pend_ns && W_ON : walk_ns && !(tick && count == W_END));
      walk_ew_n = next == EW_G && (enter_ew ? pend_ew && W_ON : walk_ew && !(tick && count == W_END));
   end
   always_ff @(posedge clk)
      if (rst) begin
         pend_ns <= 1'b0;
         pend_ew <= 1'b0;
         ns_rgy  <= RED;
         ew_rgy  <= RED;
         walk_ns <= 1'b0;
         walk_ew <= 1'b0;
      end else begin
         pend_ns <= !enter_ns && (pend_ns || ped_ns);
         pend_ew <= !enter_ew && (pend_ew || ped_ew);
         ns_rgy  <= ns_n;
         ew_rgy  <= ew_n;
         walk_ns <= walk_ns_n;
         walk_ew <= walk_ew_n;
      end
endmodule

// File: tb/tb_intersection_scheduler.sv
// tb_intersection_scheduler: directed and random checks against a tick-counting reference model
module tb_intersection_scheduler;
   import traffic_pkg::*;
   localparam int GREEN = 8, YELLOW = 2, ALLRED = 1, WALK = 4;
   logic clk = 0, rst = 1, tick = 0, off = 0, ped_ns = 0, ped_ew = 0, car_ew = 0;
   logic [2:0] ns_rgy, ew_rgy, phase;
   logic walk_ns, walk_ew, buzz_en;
   int total = 0, bad = 0;
   phase_e m_st = AR2;
   int m_el = 0, m_wns = 0, m_wew = 0;
   bit m_pns = 0, m_pew = 0;

   intersection_scheduler #(
      .GREEN_TICKS(GREEN), .YELLOW_TICKS(YELLOW), .ALLRED_TICKS(ALLRED),
      .WALK_TICKS(WALK), .TIMER_W(4)
   ) dut (
      .clk(clk), .rst(rst), .tick(tick), .off(off), .ped_ns(ped_ns), .ped_ew(ped_ew),
      .car_ew(car_ew), .ns_rgy(ns_rgy), .ew_rgy(ew_rgy), .walk_ns(walk_ns),
      .walk_ew(walk_ew), .buzz_en(buzz_en), .phase(phase)
   );

   always #5 clk = ~clk;

   function automatic int dur_of(phase_e s);
      return (s == NS_G || s == EW_G) ? GREEN : (s == NS_Y || s == EW_Y) ? YELLOW : ALLRED;
   endfunction

   function automatic phase_e succ(phase_e s);
      phase_e order [6] = '{AR2, NS_G, NS_Y, AR1, EW_G, EW_Y};
      for (int i = 0; i < 6; i++) if (order[i] == s) return order[(i + 1) % 6];
      return AR2;
   endfunction

   function automatic logic [2:0] lamp(phase_e s, phase_e g, phase_e y);
      return s == OFF ? 3'b000 : s == g ? 3'b001 : s == y ? 3'b010 : 3'b100;
   endfunction

   function automatic phase_e demand_at(int k);
      int m = k % 22;
      return m < 8 ? NS_G : m < 10 ? NS_Y : m < 11 ? AR1 : m < 19 ? EW_G : m < 21 ? EW_Y : AR2;
   endfunction

   task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_update();
      phase_e n;
      bit ent;
      if (rst) begin
         m_st = AR2; m_el = 0; m_pns = 0; m_pew = 0; m_wns = 0; m_wew = 0;
         return;
      end
      n = m_st;
      if (off) n = OFF;
      else if (m_st == OFF) n = AR2;
      else if (tick && m_el + 1 >= dur_of(m_st) && (m_st != NS_G || car_ew || m_pns || m_pew))
         n = succ(m_st);
      ent = n != m_st;
      m_wns = n != NS_G ? 0 : ent ? (m_pns ? WALK : 0) : (tick && m_wns > 0) ? m_wns - 1 : m_wns;
      m_wew = n != EW_G ? 0 : ent ? (m_pew ? WALK : 0) : (tick && m_wew > 0) ? m_wew - 1 : m_wew;
      m_pns = (ent && n == NS_G) ? 1'b0 : m_pns | ped_ns;
      m_pew = (ent && n == EW_G) ? 1'b0 : m_pew | ped_ew;
      m_el = ent ? 0 : m_el + int'(tick);
      m_st = n;
   endtask

   task automatic compare_all();
      logic viol;
      check("ns_rgy", 8'(ns_rgy), 8'(lamp(m_st, NS_G, NS_Y)));
      check("ew_rgy", 8'(ew_rgy), 8'(lamp(m_st, EW_G, EW_Y)));
      check("walk_ns", 8'(walk_ns), 8'(m_wns > 0));
      check("walk_ew", 8'(walk_ew), 8'(m_wew > 0));
      check("buzz_en", 8'(buzz_en), 8'(m_wns > 0 || m_wew > 0));
      check("phase", 8'(phase), 8'(m_st));
      viol = (ns_rgy inside {3'b001, 3'b010} && ew_rgy inside {3'b001, 3'b010}) ||
             (walk_ns && ns_rgy != 3'b001) || (walk_ew && ew_rgy != 3'b001);
      check("safety", 8'(viol), 8'd0);
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      int n, walks;
      bit seen;
      // reset, with off asserted to confirm reset wins
      rst = 1; off = 1;
      step(); step();
      check("rst_ns", 8'(ns_rgy), 8'h4);
      check("rst_ew", 8'(ew_rgy), 8'h4);
      check("rst_walk", 8'({walk_ns, walk_ew, buzz_en}), 8'h0);
      check("rst_phase", 8'(phase), 8'(AR2));
      off = 0;
      // rest in NS_G with no demand
      rst = 0; tick = 1;
      step();
      check("rest_entry", 8'(ns_rgy), 8'h1);
      repeat (40) step();
      check("rest_ns", 8'(ns_rgy), 8'h1);
      check("rest_ew", 8'(ew_rgy), 8'h4);
      // demand cycle
      rst = 1; step(); rst = 0; car_ew = 1;
      for (int k = 0; k < 44; k++) begin
         step();
         check("demand_seq", 8'(phase), 8'(demand_at(k)));
      end
      // off during EW yellow
      n = 0;
      while (m_st != EW_Y && n < 30) begin step(); n++; end
      check("reach_ew_y", 8'(phase), 8'(EW_Y));
      off = 1; step();
      check("off_ns", 8'(ns_rgy), 8'h0);
      check("off_ew", 8'(ew_rgy), 8'h0);
      step();
      off = 0; step();
      check("off_ar2_lamps", 8'({ns_rgy, ew_rgy}), 8'h24);
      check("off_ar2_phase", 8'(phase), 8'(AR2));
      step();
      check("off_resume", 8'(phase), 8'(NS_G));
      // pedestrian walk on EW
      car_ew = 0; rst = 1; step(); rst = 0; step();
      ped_ew = 1; step(); ped_ew = 0;
      walks = 0; seen = 0;
      for (int k = 0; k < 30; k++) begin
         step();
         if (walk_ew === 1'b1 && buzz_en === 1'b1) walks++;
         if (phase == EW_G && !seen) begin
            seen = 1;
            check("pend_ew_clear", 8'(dut.pend_ew), 8'h0);
         end
      end
      check("walk_len", 8'(walks), 8'd4);
      check("ew_g_seen", 8'(seen), 8'd1);
      // reset mid-walk
      rst = 1; step(); rst = 0;
      ped_ew = 1; step(); ped_ew = 0;
      ped_ns = 1; step(); ped_ns = 0;
      n = 0;
      while (!(m_st == EW_G && m_wew > 0) && n < 40) begin step(); n++; end
      check("midwalk_pre", 8'(walk_ew), 8'h1);
      check("midwalk_pend_ns", 8'(dut.pend_ns), 8'h1);
      rst = 1; step();
      check("midwalk_lamps", 8'({ns_rgy, ew_rgy}), 8'h24);
      check("midwalk_walk", 8'({walk_ns, walk_ew, buzz_en}), 8'h0);
      check("midwalk_pend", 8'({dut.pend_ns, dut.pend_ew}), 8'h0);
      rst = 0;
      // ped_ns on the NS_G entry cycle is consumed
      ped_ns = 1; step(); ped_ns = 0;
      walks = 0;
      repeat (20) begin
         step();
         if (walk_ns !== 1'b0) walks++;
      end
      check("no_second_walk", 8'(walks), 8'd0);
      check("entry_consumed", 8'(dut.pend_ns), 8'h0);
      check("entry_rest", 8'(phase), 8'(NS_G));
      // random run
      for (int k = 0; k < 2000; k++) begin
         rst = $urandom_range(0, 199) == 0;
         off = off ? $urandom_range(0, 3) != 0 : $urandom_range(0, 99) == 0;
         tick = $urandom_range(0, 2) == 0;
         ped_ns = $urandom_range(0, 19) == 0;
         ped_ew = $urandom_range(0, 19) == 0;
         if ($urandom_range(0, 31) == 0) car_ew = ~car_ew;
         step();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
